// File: rtl/serial_frame_deserializer.sv
// Assembles start/LSB-first data/stop serial frames into WIDTH-bit words held in a one-entry valid/ready register.
// Latency: 1 clk from stop-bit sample to out_valid; a full, non-draining output register drops the new word and pulses overrun.
module serial_frame_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  shift_q;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q;
    logic              ferr_q;
    logic              ovr_q;

    logic good_stop_d;
    logic load_d;

    // A good stop bit loads the output register when it is empty or draining on this edge.
    always_comb begin
        good_stop_d = (state_q == ST_STOP) && din_en && !din;
        load_d      = good_stop_d && (!valid_q || out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (din_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (din) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        shift_q <= {din, shift_q[WIDTH-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (din) begin
                            ferr_q <= 1'b1;
                        end else if (!load_d) begin
                            ovr_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
            if (load_d) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Consumes the 1-bit registered stream produced by the rising-edge D flip-flop stage (its Q output) and assembles framed serial words.
- Frame format: one start bit (1), then WIDTH data bits LSB first, then one stop bit (0).
- Delivers each completed word through a one-entry valid/ready output register.
- Flags framing errors and overruns so the downstream consumer sees only good words.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
- din  input  1  serial data bit, driven by the flip-flop stage Q.
- din_en  input  1  sample strobe; din is consumed only on rising edges where din_en=1.
- data_out  output  WIDTH  assembled word; valid while out_valid=1.
- out_valid  output  1  word available in the output register.
- out_ready  input  1  consumer accepts data_out on an edge where out_valid=1 and out_ready=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
- overrun  output  1  one-cycle pulse: good frame completed while the output register was full and not draining.

Behaviour:
- Reset (reset=0): state=IDLE, bit counter=0, shift register=0, data_out=0, out_valid=0, frame_err=0, overrun=0. Reset asserted mid-frame discards the partial frame. Reset asserted with out_valid=1 discards the held word.
- Edges with din_en=0: FSM, counter and shift register hold. Output handshake still operates.
- State machine:
  - IDLE: on din_en=1 and din=1 (start bit), go to SHIFT and clear the counter. din=0 stays in IDLE (line idle).
  - SHIFT: on each din_en=1, shift_reg <= {din, shift_reg[WIDTH-1:1]} and increment the counter. When the counter reaches WIDTH-1 on a sampled bit, go to STOP.
  - STOP: on din_en=1, always return to IDLE.
    - din=0 (good stop bit): deliver the word.
    - din=1: frame_err=1 for exactly the next cycle; word dropped; out_valid and data_out unchanged.
  - No direct STOP->SHIFT transition. A start bit arriving right after a stop bit needs another din_en in IDLE.
- Delivery on a good stop bit:
  - If out_valid=0, or out_valid=1 and out_ready=1 on the same edge: data_out <= shift_reg and out_valid=1 from the next cycle. Latency: stop-bit sampling edge to out_valid high = 1 clk.
  - Otherwise the held word is kept, the new word is dropped, and overrun=1 for exactly the next cycle.
- Output handshake:
  - out_valid stays 1 and data_out stays stable until an edge with out_ready=1.
  - On that edge, out_valid clears unless a new word loads simultaneously; in that case it stays 1 with the new data.
  - out_ready while out_valid=0 has no effect.
- frame_err and overrun are registered pulses and are never both 1 in the same cycle.
- Counter width is clog2(WIDTH) bits and is cleared on every IDLE->SHIFT transition.

Test Plan:
- Reset: hold reset=0, toggle clk and din=1/din_en=1 -> all outputs 0, FSM remains in IDLE. Release reset -> no spurious out_valid.
- Good frame, WIDTH=8, din_en=1 every cycle, out_ready=1: sequence 1, 1,0,1,0,0,1,0,1, 0 -> data_out=8'hA5, out_valid=1 exactly 1 cycle after the stop-bit edge, then cleared the next cycle.
- Sparse strobe: same 0xA5 frame with din_en=1 every 3rd cycle and random din on the other cycles -> data_out=8'hA5, with no effect from non-strobed cycles.
- Framing error: start, data 0x3C, stop=1 -> frame_err pulses 1 cycle, out_valid stays 0. A following good frame 0x81 -> data_out=8'h81.
- Backpressure and overrun:
  - out_ready=0; send 0x11 then 0x22 -> data_out=8'h11 held, overrun pulses 1 cycle after frame 0x22's stop bit.
  - Raise out_ready on the same edge as a third frame 0x33's stop bit -> out_valid remains 1 with data_out=8'h33.
- Async reset mid-frame: assert reset=0 between clk edges after 4 data bits -> outputs clear before the next edge. Release, send 0x5A -> data_out=8'h5A, with no stale bits.
